trdb_instr_tracker: RTL and testbench
=====================================

Name: trdb_instr_tracker

Overview:
- Sits directly upstream of the trace encoder's priority stage.
- Takes one retired-instruction record per cycle from the core interface and holds a 3-deep shift pipeline: nc = newest, tc = middle, lc = oldest.
- From that pipeline it derives every last-cycle, this-cycle and next-cycle qualifier the priority stage consumes, plus the resync-timer comparisons and the enable/opmode edge pulses.

Parameters:
- PRIV_W, 2, privilege-level width.
- CTX_W, 32, context-ID width.
- RESYNC_MAX, 16'd1000, number of instruction shifts between forced resyncs.
- CNT_W, 16, resync counter width; RESYNC_MAX+1 must fit in CNT_W bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  instruction retired this cycle; advances the pipeline
- qualified_i  in  1  instruction passes filter
- exception_i  in  1  instruction took exception or interrupt
- updiscon_i  in  1  uninferable discontinuity
- branch_i  in  1  instruction is a conditional branch
- priv_i  in  PRIV_W  privilege level
- context_i  in  CTX_W  context ID
- trace_enable_i  in  1  encoder enable (level)
- opmode_i  in  2  encoder operating mode
- branch_map_empty_i  in  1  branch map currently empty
- branch_map_full_i  in  1  branch map currently full
- resync_timer_rst_i  in  1  from priority stage; clears resync counter
- valid_o  out  1  tc stage holds a new instruction for priority
- lc_exception_o, lc_updiscon_o, lc_final_qualified_o  out  1 each
- tc_qualified_o, tc_exception_o, tc_retired_o, tc_first_qualified_o, tc_privchange_o, tc_context_change_o  out  1 each
- tc_gt_max_resync_o, tc_et_max_resync_o  out  1 each
- tc_branch_map_empty_o, tc_branch_map_full_o  out  1 each
- tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o  out  1 each
- nc_exception_o, nc_privchange_o, nc_context_change_o, nc_branch_map_empty_o, nc_qualified_o, nc_retired_o  out  1 each

Behaviour:
- Reset (async, rst_ni=0):
  - All stage registers cleared, including stage-valid bits s0_v, s1_v and s2_v.
  - Resync counter = 0; edge-detect registers = 0; opmode register = 0.
  - All outputs = 0.
- Shift (valid_i=1, on the clock edge): stage2←stage1, stage1←stage0, stage0←inputs, s0_v←1. With valid_i=0 every stage holds.
- Stage fields: qualified, exception, updiscon, branch, priv, context.
- valid_o: registered copy of valid_i, ANDed with s1_v. It is a one-cycle pulse in the cycle after each shift, once the tc stage is occupied.
- Retired outputs: nc_retired_o = s0_v; tc_retired_o = s1_v.
- Field outputs: nc_* come from stage0, tc_* from stage1 and lc_* from stage2. Each is gated by its stage-valid bit.
- Qualifier derivations:
  - tc_first_qualified_o = tc.qualified & ~(s2_v & lc.qualified).
  - lc_final_qualified_o = s2_v & lc.qualified & ~(s1_v & tc.qualified).
  - tc_privchange_o = s2_v & tc.qualified & lc.qualified & (tc.priv≠lc.priv).
  - nc_privchange_o is the same comparison applied to nc vs tc.
  - Context-change outputs follow the same rules using context.
- Branch map outputs:
  - tc_branch_map_empty_o = branch_map_empty_i; tc_branch_map_full_o = branch_map_full_i.
  - nc_branch_map_empty_o = branch_map_empty_i & ~(s1_v & tc.branch & tc.qualified).
- Resync counter:
  - Increments by 1 on each shift where the incoming instruction is qualified.
  - Saturates at RESYNC_MAX+1.
  - resync_timer_rst_i=1 clears it to 0 and takes precedence over a simultaneous increment.
  - tc_et_max_resync_o = (cnt==RESYNC_MAX); tc_gt_max_resync_o = (cnt>RESYNC_MAX).
- Enable edges:
  - trace_enable_i is registered into en_q.
  - A 0→1 edge arms a sticky enabled-pending flag; a 1→0 edge arms disabled-pending.
  - Each pending flag drives tc_enc_enabled_o / tc_enc_disabled_o while set and clears in the cycle valid_o=1, so the pulse aligns with the next instruction presented.
  - If both edges occur before consumption, both flags remain set.
- Opmode change: a change of opmode_i vs the registered copy arms tc_opmode_change_o, using the same sticky/clear rule as the enable edges.
- Latency: an instruction appears on nc_* one cycle after capture, on tc_* after the next shift, and on lc_* after the shift after that.
- Reset mid-stream: the pipeline empties. The next first qualified instruction then asserts tc_first_qualified_o, because s2_v=0.

Test Plan:
- Reset then 3 qualified shifts (priv=3) -> valid_o pulses on cycles 2 and 3; tc_first_qualified_o=1 only on the first valid_o; tc_privchange_o=0.
- Shifts with priv 3,3,1, all qualified -> tc_privchange_o=1 when tc.priv=1 and lc.priv=3; nc_privchange_o=1 one shift earlier.
- Qualified, qualified, unqualified -> lc_final_qualified_o=1 exactly when lc is the second instruction and tc is the unqualified one.
- RESYNC_MAX=4, 6 qualified shifts -> tc_et_max_resync_o=1 at cnt 4; tc_gt_max_resync_o=1 at cnt 5 and stays there (saturation). Pulse resync_timer_rst_i together with a shift -> cnt=0.
- trace_enable_i 0→1 with no valid_i for 5 cycles, then one shift -> tc_enc_enabled_o held high until and including the valid_o cycle, then 0.
- Drop rst_ni mid-stream with the pipeline full -> all outputs 0 asynchronously; the next qualified instruction yields tc_first_qualified_o=1.

Source files
------------

// File: rtl/trdb_instr_tracker.sv
// Three-deep retired-instruction pipeline (nc/tc/lc) feeding the trace priority stage with qualifiers.
// Latency: nc one cycle after capture, tc/lc after the next shifts; no backpressure, valid_i simply advances stages.
module trdb_instr_tracker #(
    parameter int                 PRIV_W     = 2,
    parameter int                 CTX_W      = 32,
    parameter int                 CNT_W      = 16,
    parameter logic [CNT_W-1:0]   RESYNC_MAX = 16'd1000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              qualified_i,
    input  logic              exception_i,
    input  logic              updiscon_i,
    input  logic              branch_i,
    input  logic [PRIV_W-1:0] priv_i,
    input  logic [CTX_W-1:0]  context_i,
    input  logic              trace_enable_i,
    input  logic [1:0]        opmode_i,
    input  logic              branch_map_empty_i,
    input  logic              branch_map_full_i,
    input  logic              resync_timer_rst_i,
    output logic              valid_o,
    output logic              lc_exception_o,
    output logic              lc_updiscon_o,
    output logic              lc_final_qualified_o,
    output logic              tc_qualified_o,
    output logic              tc_exception_o,
    output logic              tc_retired_o,
    output logic              tc_first_qualified_o,
    output logic              tc_privchange_o,
    output logic              tc_context_change_o,
    output logic              tc_gt_max_resync_o,
    output logic              tc_et_max_resync_o,
    output logic              tc_branch_map_empty_o,
    output logic              tc_branch_map_full_o,
    output logic              tc_enc_enabled_o,
    output logic              tc_enc_disabled_o,
    output logic              tc_opmode_change_o,
    output logic              nc_exception_o,
    output logic              nc_privchange_o,
    output logic              nc_context_change_o,
    output logic              nc_branch_map_empty_o,
    output logic              nc_qualified_o,
    output logic              nc_retired_o
);

    typedef struct packed {
        logic              qualified;
        logic              exception;
        logic              updiscon;
        logic              branch;
        logic [PRIV_W-1:0] priv;
        logic [CTX_W-1:0]  ctx;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_SAT = RESYNC_MAX + {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           s0, s1, s2;
    logic             s0_v, s1_v, s2_v;
    logic             valid_q;
    logic [CNT_W-1:0] cnt;
    logic             en_q;
    logic [1:0]       opmode_q;
    logic             enabled_pend, disabled_pend, opmode_pend;
    logic             en_rise, en_fall, opmode_chg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0      <= '0;
            s1      <= '0;
            s2      <= '0;
            s0_v    <= 1'b0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                s2           <= s1;
                s2_v         <= s1_v;
                s1           <= s0;
                s1_v         <= s0_v;
                s0.qualified <= qualified_i;
                s0.exception <= exception_i;
                s0.updiscon  <= updiscon_i;
                s0.branch    <= branch_i;
                s0.priv      <= priv_i;
                s0.ctx       <= context_i;
                s0_v         <= 1'b1;
            end
        end
    end

    // Timer reset from the priority stage beats a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (resync_timer_rst_i) begin
            cnt <= '0;
        end else if (valid_i && qualified_i && (cnt != CNT_SAT)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign en_rise    = trace_enable_i & ~en_q;
    assign en_fall    = ~trace_enable_i & en_q;
    assign opmode_chg = (opmode_i != opmode_q);

    // Pending flags stay up until an instruction is presented; a fresh edge wins over the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q          <= 1'b0;
            opmode_q      <= 2'b00;
            enabled_pend  <= 1'b0;
            disabled_pend <= 1'b0;
            opmode_pend   <= 1'b0;
        end else begin
            en_q          <= trace_enable_i;
            opmode_q      <= opmode_i;
            enabled_pend  <= en_rise    | (enabled_pend  & ~valid_o);
            disabled_pend <= en_fall    | (disabled_pend & ~valid_o);
            opmode_pend   <= opmode_chg | (opmode_pend   & ~valid_o);
        end
    end

    assign valid_o               = valid_q & s1_v;

    assign nc_retired_o          = s0_v;
    assign tc_retired_o          = s1_v;

    assign nc_qualified_o        = s0_v & s0.qualified;
    assign nc_exception_o        = s0_v & s0.exception;
    assign tc_qualified_o        = s1_v & s1.qualified;
    assign tc_exception_o        = s1_v & s1.exception;
    assign lc_exception_o        = s2_v & s2.exception;
    assign lc_updiscon_o         = s2_v & s2.updiscon;

    assign tc_first_qualified_o  = s1_v & s1.qualified & ~(s2_v & s2.qualified);
    assign lc_final_qualified_o  = s2_v & s2.qualified & ~(s1_v & s1.qualified);

    assign tc_privchange_o       = s2_v & s1_v & s1.qualified & s2.qualified & (s1.priv != s2.priv);
    assign nc_privchange_o       = s1_v & s0_v & s0.qualified & s1.qualified & (s0.priv != s1.priv);
    assign tc_context_change_o   = s2_v & s1_v & s1.qualified & s2.qualified & (s1.ctx != s2.ctx);
    assign nc_context_change_o   = s1_v & s0_v & s0.qualified & s1.qualified & (s0.ctx != s1.ctx);

    assign tc_branch_map_empty_o = branch_map_empty_i;
    assign tc_branch_map_full_o  = branch_map_full_i;
    assign nc_branch_map_empty_o = branch_map_empty_i & ~(s1_v & s1.branch & s1.qualified);

    assign tc_et_max_resync_o    = (cnt == RESYNC_MAX);
    assign tc_gt_max_resync_o    = (cnt > RESYNC_MAX);

    assign tc_enc_enabled_o      = enabled_pend;
    assign tc_enc_disabled_o     = disabled_pend;
    assign tc_opmode_change_o    = opmode_pend;

endmodule

// File: tb/tb_trdb_instr_tracker.sv
// Directed bench for trdb_instr_tracker; expected values are hand-derived per scenario.
module tb_trdb_instr_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i, qualified_i, exception_i, updiscon_i, branch_i;
    logic [1:0]  priv_i;
    logic [31:0] context_i;
    logic        trace_enable_i;
    logic [1:0]  opmode_i;
    logic        branch_map_empty_i, branch_map_full_i, resync_timer_rst_i;

    logic valid_o, lc_exception_o, lc_updiscon_o, lc_final_qualified_o;
    logic tc_qualified_o, tc_exception_o, tc_retired_o, tc_first_qualified_o;
    logic tc_privchange_o, tc_context_change_o, tc_gt_max_resync_o, tc_et_max_resync_o;
    logic tc_branch_map_empty_o, tc_branch_map_full_o;
    logic tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o;
    logic nc_exception_o, nc_privchange_o, nc_context_change_o;
    logic nc_branch_map_empty_o, nc_qualified_o, nc_retired_o;

    int checks = 0;
    int errors = 0;

    logic [22:0] all_out;
    assign all_out = {valid_o, lc_exception_o, lc_updiscon_o, lc_final_qualified_o,
                      tc_qualified_o, tc_exception_o, tc_retired_o, tc_first_qualified_o,
                      tc_privchange_o, tc_context_change_o, tc_gt_max_resync_o, tc_et_max_resync_o,
                      tc_branch_map_empty_o, tc_branch_map_full_o, tc_enc_enabled_o,
                      tc_enc_disabled_o, tc_opmode_change_o, nc_exception_o, nc_privchange_o,
                      nc_context_change_o, nc_branch_map_empty_o, nc_qualified_o, nc_retired_o};

    trdb_instr_tracker #(
        .PRIV_W(2), .CTX_W(32), .CNT_W(16), .RESYNC_MAX(16'd4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .qualified_i(qualified_i),
        .exception_i(exception_i), .updiscon_i(updiscon_i), .branch_i(branch_i),
        .priv_i(priv_i), .context_i(context_i), .trace_enable_i(trace_enable_i),
        .opmode_i(opmode_i), .branch_map_empty_i(branch_map_empty_i),
        .branch_map_full_i(branch_map_full_i), .resync_timer_rst_i(resync_timer_rst_i),
        .valid_o(valid_o), .lc_exception_o(lc_exception_o), .lc_updiscon_o(lc_updiscon_o),
        .lc_final_qualified_o(lc_final_qualified_o), .tc_qualified_o(tc_qualified_o),
        .tc_exception_o(tc_exception_o), .tc_retired_o(tc_retired_o),
        .tc_first_qualified_o(tc_first_qualified_o), .tc_privchange_o(tc_privchange_o),
        .tc_context_change_o(tc_context_change_o), .tc_gt_max_resync_o(tc_gt_max_resync_o),
        .tc_et_max_resync_o(tc_et_max_resync_o), .tc_branch_map_empty_o(tc_branch_map_empty_o),
        .tc_branch_map_full_o(tc_branch_map_full_o), .tc_enc_enabled_o(tc_enc_enabled_o),
        .tc_enc_disabled_o(tc_enc_disabled_o), .tc_opmode_change_o(tc_opmode_change_o),
        .nc_exception_o(nc_exception_o), .nc_privchange_o(nc_privchange_o),
        .nc_context_change_o(nc_context_change_o), .nc_branch_map_empty_o(nc_branch_map_empty_o),
        .nc_qualified_o(nc_qualified_o), .nc_retired_o(nc_retired_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic q, input logic [1:0] p,
                         input logic [31:0] c, input logic br);
        valid_i     = v;
        qualified_i = q;
        priv_i      = p;
        context_i   = c;
        branch_i    = br;
        cyc();
    endtask

    task automatic clear_inputs();
        valid_i = 0; qualified_i = 0; exception_i = 0; updiscon_i = 0; branch_i = 0;
        priv_i = 0; context_i = 0; trace_enable_i = 0; opmode_i = 0;
        branch_map_empty_i = 0; branch_map_full_i = 0; resync_timer_rst_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #3;
        checks++;
        if (all_out !== 23'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", all_out, 23'h0);
        end
        cyc();
        rst_ni = 1'b1;
        cyc();
        checks++;
        if (all_out !== 23'h0) begin
            errors++; $display("FAIL post_reset_idle got %h exp %h", all_out, 23'h0);
        end
    endtask

    task automatic test_first_qualified();
        do_reset();
        drive(1, 1, 2'd3, 32'h0, 0);
        checks++;
        if ({valid_o, nc_retired_o, tc_retired_o} !== 3'b010) begin
            errors++; $display("FAIL fq_shift1 got %b exp %b", {valid_o, nc_retired_o, tc_retired_o}, 3'b010);
        end
        drive(1, 1, 2'd3, 32'h0, 0);
        checks++;
        if ({valid_o, tc_first_qualified_o, tc_privchange_o} !== 3'b110) begin
            errors++; $display("FAIL fq_shift2 got %b exp %b", {valid_o, tc_first_qualified_o, tc_privchange_o}, 3'b110);
        end
        drive(1, 1, 2'd3, 32'h0, 0);
        checks++;
        if ({valid_o, tc_first_qualified_o, tc_privchange_o} !== 3'b100) begin
            errors++; $display("FAIL fq_shift3 got %b exp %b", {valid_o, tc_first_qualified_o, tc_privchange_o}, 3'b100);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL fq_idle_valid got %b exp %b", valid_o, 1'b0);
        end
    endtask

    task automatic test_privchange();
        do_reset();
        drive(1, 1, 2'd3, 32'hA, 0);
        drive(1, 1, 2'd3, 32'hA, 0);
        checks++;
        if ({nc_privchange_o, nc_context_change_o} !== 2'b00) begin
            errors++; $display("FAIL pc_shift2 got %b exp %b", {nc_privchange_o, nc_context_change_o}, 2'b00);
        end
        drive(1, 1, 2'd1, 32'hB, 0);
        checks++;
        if ({nc_privchange_o, nc_context_change_o, tc_privchange_o, tc_context_change_o} !== 4'b1100) begin
            errors++; $display("FAIL pc_shift3 got %b exp %b",
                {nc_privchange_o, nc_context_change_o, tc_privchange_o, tc_context_change_o}, 4'b1100);
        end
        drive(1, 1, 2'd1, 32'hB, 0);
        checks++;
        if ({nc_privchange_o, nc_context_change_o, tc_privchange_o, tc_context_change_o} !== 4'b0011) begin
            errors++; $display("FAIL pc_shift4 got %b exp %b",
                {nc_privchange_o, nc_context_change_o, tc_privchange_o, tc_context_change_o}, 4'b0011);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
    endtask

    task automatic test_final_qualified();
        do_reset();
        drive(1, 1, 2'd0, 32'h0, 0);
        drive(1, 1, 2'd0, 32'h0, 0);
        drive(1, 0, 2'd0, 32'h0, 0);
        checks++;
        if (lc_final_qualified_o !== 1'b0) begin
            errors++; $display("FAIL lf_shift3 got %b exp %b", lc_final_qualified_o, 1'b0);
        end
        drive(1, 0, 2'd0, 32'h0, 0);
        checks++;
        if ({lc_final_qualified_o, tc_qualified_o} !== 2'b10) begin
            errors++; $display("FAIL lf_shift4 got %b exp %b", {lc_final_qualified_o, tc_qualified_o}, 2'b10);
        end
        drive(1, 0, 2'd0, 32'h0, 0);
        checks++;
        if (lc_final_qualified_o !== 1'b0) begin
            errors++; $display("FAIL lf_shift5 got %b exp %b", lc_final_qualified_o, 1'b0);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
    endtask

    task automatic test_branch_map();
        do_reset();
        branch_map_empty_i = 1;
        branch_map_full_i  = 1;
        drive(1, 1, 2'd0, 32'h0, 1);
        checks++;
        if ({tc_branch_map_empty_o, tc_branch_map_full_o, nc_branch_map_empty_o} !== 3'b111) begin
            errors++; $display("FAIL bm_shift1 got %b exp %b",
                {tc_branch_map_empty_o, tc_branch_map_full_o, nc_branch_map_empty_o}, 3'b111);
        end
        drive(1, 1, 2'd0, 32'h0, 0);
        checks++;
        if (nc_branch_map_empty_o !== 1'b0) begin
            errors++; $display("FAIL bm_tc_branch got %b exp %b", nc_branch_map_empty_o, 1'b0);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
        branch_map_empty_i = 0;
        branch_map_full_i  = 0;
    endtask

    task automatic test_resync();
        logic [1:0] exp_q [1:6];
        exp_q[1] = 2'b00; exp_q[2] = 2'b00; exp_q[3] = 2'b00;
        exp_q[4] = 2'b01; exp_q[5] = 2'b10; exp_q[6] = 2'b10;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1, 1, 2'd0, 32'h0, 0);
            checks++;
            if ({tc_gt_max_resync_o, tc_et_max_resync_o} !== exp_q[k]) begin
                errors++; $display("FAIL rs_shift%0d got %b exp %b", k,
                    {tc_gt_max_resync_o, tc_et_max_resync_o}, exp_q[k]);
            end
        end
        resync_timer_rst_i = 1;
        drive(1, 1, 2'd0, 32'h0, 0);
        resync_timer_rst_i = 0;
        checks++;
        if ({tc_gt_max_resync_o, tc_et_max_resync_o} !== 2'b00) begin
            errors++; $display("FAIL rs_clear got %b exp %b", {tc_gt_max_resync_o, tc_et_max_resync_o}, 2'b00);
        end
        for (int k = 1; k <= 3; k++) drive(1, 1, 2'd0, 32'h0, 0);
        checks++;
        if (tc_et_max_resync_o !== 1'b0) begin
            errors++; $display("FAIL rs_recount3 got %b exp %b", tc_et_max_resync_o, 1'b0);
        end
        drive(1, 1, 2'd0, 32'h0, 0);
        checks++;
        if (tc_et_max_resync_o !== 1'b1) begin
            errors++; $display("FAIL rs_recount4 got %b exp %b", tc_et_max_resync_o, 1'b1);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
    endtask

    task automatic test_enable_edges();
        do_reset();
        drive(1, 1, 2'd0, 32'h0, 0);
        drive(1, 1, 2'd0, 32'h0, 0);
        drive(0, 0, 2'd0, 32'h0, 0);
        drive(0, 0, 2'd0, 32'h0, 0);
        trace_enable_i = 1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if ({tc_enc_enabled_o, valid_o} !== 2'b10) begin
                errors++; $display("FAIL en_wait%0d got %b exp %b", k, {tc_enc_enabled_o, valid_o}, 2'b10);
            end
        end
        drive(1, 1, 2'd0, 32'h0, 0);
        checks++;
        if ({tc_enc_enabled_o, valid_o} !== 2'b11) begin
            errors++; $display("FAIL en_present got %b exp %b", {tc_enc_enabled_o, valid_o}, 2'b11);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
        checks++;
        if ({tc_enc_enabled_o, valid_o} !== 2'b00) begin
            errors++; $display("FAIL en_consumed got %b exp %b", {tc_enc_enabled_o, valid_o}, 2'b00);
        end
        trace_enable_i = 0;
        opmode_i = 2'd2;
        cyc();
        trace_enable_i = 1;
        cyc();
        checks++;
        if ({tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o} !== 3'b111) begin
            errors++; $display("FAIL en_both got %b exp %b",
                {tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o}, 3'b111);
        end
        drive(1, 1, 2'd0, 32'h0, 0);
        drive(0, 0, 2'd0, 32'h0, 0);
        checks++;
        if ({tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o} !== 3'b000) begin
            errors++; $display("FAIL en_both_consumed got %b exp %b",
                {tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o}, 3'b000);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        exception_i = 1;
        updiscon_i  = 1;
        for (int k = 0; k < 3; k++) drive(1, 1, 2'd0, 32'h0, 0);
        checks++;
        if ({lc_exception_o, lc_updiscon_o, valid_o} !== 3'b111) begin
            errors++; $display("FAIL mid_full got %b exp %b", {lc_exception_o, lc_updiscon_o, valid_o}, 3'b111);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (all_out !== 23'h0) begin
            errors++; $display("FAIL mid_async_reset got %h exp %h", all_out, 23'h0);
        end
        clear_inputs();
        cyc();
        rst_ni = 1'b1;
        drive(1, 1, 2'd0, 32'h0, 0);
        drive(1, 1, 2'd0, 32'h0, 0);
        checks++;
        if ({tc_first_qualified_o, valid_o, lc_final_qualified_o} !== 3'b110) begin
            errors++; $display("FAIL mid_first_qual got %b exp %b",
                {tc_first_qualified_o, valid_o, lc_final_qualified_o}, 3'b110);
        end
        drive(0, 0, 2'd0, 32'h0, 0);
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b1;
        test_reset();
        test_first_qualified();
        test_privchange();
        test_final_qualified();
        test_branch_map();
        test_resync();
        test_enable_edges();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
